// File: rtl/vanilla_hazard_scoreboard.sv
// Issue-stage hazard scoreboard: pending-write bits for the integer/FP register files plus a memory credit counter.
// Optional FP register tracking is enabled by defining VANILLA_SCOREBOARD_FP_EN.
module vanilla_hazard_scoreboard #(
    parameter  int MAX_OUT = 16,
    localparam int OUT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,

    input  logic             issue_v_i,
    output logic             issue_ready_o,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [4:0]       rd_i,
    input  logic             reads_rf1_i,
    input  logic             reads_rf2_i,
    input  logic             writes_rf_i,
    input  logic             reads_fp_rf1_i,
    input  logic             reads_fp_rf2_i,
    input  logic             writes_fp_rf_i,
    input  logic             long_lat_i,
    input  logic             mem_op_i,
    input  logic             fence_i,

    input  logic             int_wb_v_i,
    input  logic [4:0]       int_wb_id_i,
    input  logic             fp_wb_v_i,
    input  logic [4:0]       fp_wb_id_i,
    input  logic             mem_resp_v_i,

    output logic [OUT_W-1:0] outstanding_o,
    output logic             stall_raw_o,
    output logic             stall_waw_o,
    output logic             stall_fence_o,
    output logic             stall_credit_o,
    output logic             underflow_o
);

    localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUT);

    logic [31:0]      int_pend;
    logic [31:0]      int_clr;
    logic [31:0]      int_set;
    logic [31:0]      eff_int;
    logic [31:0]      eff_fp;
    logic             fp_any;
    logic [OUT_W-1:0] out_cnt;
    logic             underflow;
    logic             fire;
    logic             inc;
    logic             dec;

    // Same-cycle writebacks bypass into the hazard check by masking the pending bit.
    assign int_clr = int_wb_v_i ? (32'd1 << int_wb_id_i) : 32'd0;
    assign eff_int = int_pend & ~int_clr;

    // x0 is hard-wired, so a late write to it never becomes pending.
    assign int_set = (fire && long_lat_i && !writes_fp_rf_i && (rd_i != 5'd0))
                     ? (32'd1 << rd_i) : 32'd0;

`ifdef VANILLA_SCOREBOARD_FP_EN
    logic [31:0] fp_pend;
    logic [31:0] fp_clr;
    logic [31:0] fp_set;

    assign fp_clr = fp_wb_v_i ? (32'd1 << fp_wb_id_i) : 32'd0;
    assign fp_set = (fire && long_lat_i && writes_fp_rf_i) ? (32'd1 << rd_i) : 32'd0;
    assign eff_fp = fp_pend & ~fp_clr;
    assign fp_any = |fp_pend;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fp_pend <= '0;
        end else begin
            fp_pend <= (fp_pend & ~fp_clr) | fp_set;
        end
    end
`else
    logic unused_fp;

    assign eff_fp    = '0;
    assign fp_any    = 1'b0;
    assign unused_fp = ^{fp_wb_v_i, fp_wb_id_i};
`endif

    // NOTE: every output of a combinational block gets a default first so no latch can be inferred.
    always_comb begin
        stall_raw_o    = 1'b0;
        stall_waw_o    = 1'b0;
        stall_fence_o  = 1'b0;
        stall_credit_o = 1'b0;
        if (issue_v_i) begin
            stall_raw_o    = (reads_rf1_i    && eff_int[rs1_i]) ||
                             (reads_rf2_i    && eff_int[rs2_i]) ||
                             (reads_fp_rf1_i && eff_fp[rs1_i])  ||
                             (reads_fp_rf2_i && eff_fp[rs2_i]);
            stall_waw_o    = (writes_rf_i    && eff_int[rd_i]) ||
                             (writes_fp_rf_i && eff_fp[rd_i]);
            // Fences drain on the registered state, not on bypassed writebacks.
            stall_fence_o  = fence_i && ((out_cnt != '0) || (|int_pend) || fp_any);
            stall_credit_o = mem_op_i && (out_cnt == MAX_CNT) && !mem_resp_v_i;
        end
    end

    assign issue_ready_o = !(stall_raw_o || stall_waw_o || stall_fence_o || stall_credit_o);
    assign fire          = issue_v_i && issue_ready_o;
    assign inc           = fire && mem_op_i;
    assign dec           = mem_resp_v_i;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            int_pend  <= '0;
            out_cnt   <= '0;
            underflow <= 1'b0;
        end else begin
            // Clear first, then set: a set and clear to the same bit leaves it set.
            int_pend <= (int_pend & ~int_clr) | int_set;
            unique case ({inc, dec})
                2'b10: out_cnt <= out_cnt + 1'b1;
                2'b01: begin
                    if (out_cnt == '0) begin
                        underflow <= 1'b1;
                    end else begin
                        out_cnt <= out_cnt - 1'b1;
                    end
                end
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    assign outstanding_o = out_cnt;
    assign underflow_o   = underflow;

endmodule
